// File: rtl/prv32_muldiv_pkg.sv
// rtl/prv32_muldiv_pkg.sv - funct3 op codes and FSM state encodings for the RV32M mul/div unit
package prv32_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/prv32_cond_negate.sv
// rtl/prv32_cond_negate.sv - two's-complement negate of x when en is set
module prv32_cond_negate #(
    parameter int XLEN = 32
) (
    input  logic            en,
    input  logic [XLEN-1:0] x,
    output logic [XLEN-1:0] y
);

    assign y = en ? -x : x;

endmodule

// File: rtl/prv32_muldiv_unit.sv
// rtl/prv32_muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit
// Divider datapath is built only when PRV32_MULDIV_DIV_EN is defined.
module prv32_muldiv_unit
    import prv32_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] r,
    output logic            illegal
);

    localparam int CW = $clog2(XLEN);

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   r_q, r_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;

    logic              a_sgn, b_sgn, res_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] fin_src, fin_val;

    assign a_sgn   = a[XLEN-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    assign b_sgn   = b[XLEN-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
    assign res_neg = (op == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);

    prv32_cond_negate #(.XLEN(XLEN)) u_neg_a (.en(a_sgn), .x(a), .y(a_mag));
    prv32_cond_negate #(.XLEN(XLEN)) u_neg_b (.en(b_sgn), .x(b), .y(b_mag));

    // Accumulator holds {high, multiplier} for multiply and {remainder, quotient} for divide.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

`ifdef PRV32_MULDIV_DIV_EN
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    logic [XLEN:0]     rem_sh, diff;
    logic [2*XLEN-1:0] div_next;
    logic              div_zero, div_ovf;

    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign diff     = rem_sh - {1'b0, mcand_q};
    assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = op[2] && !op[0] && (a == MIN_INT) && (b == ALL_ONES);
`endif

    // Quotient/remainder are zero-extended so one wide negator serves every op.
    assign fin_src = !op_q[2] ? acc_q :
                     op_q[1]  ? {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]} :
                                {{XLEN{1'b0}}, acc_q[XLEN-1:0]};

    prv32_cond_negate #(.XLEN(2*XLEN)) u_neg_res (.en(neg_q), .x(fin_src), .y(fin_val));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    mcand_d = b_mag;
                    neg_d   = res_neg;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    cnt_d   = '0;
                    state_d = ST_RUN;
`ifdef PRV32_MULDIV_DIV_EN
                    // Special results are preloaded so FIN's normal select yields them.
                    if (div_zero) begin
                        acc_d   = {a, ALL_ONES};
                        neg_d   = 1'b0;
                        state_d = ST_FIN;
                    end else if (div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, a};
                        neg_d   = 1'b0;
                        state_d = ST_FIN;
                    end
`else
                    if (op[2]) begin
                        acc_d   = '0;
                        neg_d   = 1'b0;
                        state_d = ST_FIN;
                    end
`endif
                end
            end
            ST_RUN: begin
`ifdef PRV32_MULDIV_DIV_EN
                acc_d = op_q[2] ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                r_d     = (op_q == OP_MUL || op_q[2]) ? fin_val[XLEN-1:0] : fin_val[2*XLEN-1:XLEN];
                done_d  = 1'b1;
`ifdef PRV32_MULDIV_DIV_EN
                illegal_d = 1'b0;
`else
                illegal_d = op_q[2];
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            r_q       <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign r       = r_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_prv32_muldiv_unit.sv
// tb/tb_prv32_muldiv_unit.sv - directed and random scoreboard bench for prv32_muldiv_unit
module tb_prv32_muldiv_unit;

    localparam logic [31:0] MIN_INT  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, illegal;
    logic [31:0] r;

    typedef struct {
        logic [31:0] r;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

`ifdef PRV32_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    prv32_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .r(r), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, ux, uy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o[2] && !DIV_EN) return 32'h0;
        case (o)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return ALL_ONES;
                if (x == MIN_INT && y == ALL_ONES) return x;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 0) ? ALL_ONES : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN_INT && y == ALL_ONES) return 32'h0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (!DIV_EN || y == 0 || (!o[0] && x == MIN_INT && y == ALL_ONES))) return 2;
        return 34;
    endfunction

    // Called just after a negedge; drives one op and waits (bounded) for its done pulse.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic ei, input int elat,
                          input int inj_cyc, input logic [2:0] io, input logic [31:0] ix, input logic [31:0] iy);
        int          cyc;
        bit          busy_ok, r_ok;
        logic [31:0] r_prev;
        exp_t        e;
        sb_q.push_back('{er, ei, elat});
        r_prev  = r;
        busy_ok = 1'b1;
        r_ok    = 1'b1;
        cyc     = 0;
        op = o; a = x; b = y; start = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == inj_cyc);
            if (cyc == inj_cyc) begin op = io; a = ix; b = iy; end
            if (!done) begin
                if (!busy) busy_ok = 1'b0;
                if (r !== r_prev) r_ok = 1'b0;
            end
        end while (!done && cyc < 200);
        start = 1'b0;
        chk({tag, "_done_seen"}, done, 1'b1);
        e = sb_q.pop_front();
        chk({tag, "_r"}, r, e.r);
        chk({tag, "_illegal"}, illegal, e.ill);
        chk({tag, "_latency"}, cyc, e.lat);
        chk({tag, "_busy_during"}, busy_ok, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_r_stable"}, r_ok, 1'b1);
    endtask

    task automatic run_std(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] er_div, input logic [31:0] er_nodiv);
        logic [31:0] er;
        er = DIV_EN ? er_div : er_nodiv;
        run_op(tag, o, x, y, er, o[2] && !DIV_EN, model_lat(o, x, y), 0, 3'd0, 32'd0, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_r", r, 32'h0);
        chk("reset_illegal", illegal, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_std("mul_7xm3",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFEB);
        run_std("mulh_min",      3'd1, MIN_INT,      MIN_INT,       32'h4000_0000, 32'h4000_0000);
        run_std("mulhu_ones",    3'd3, ALL_ONES,     ALL_ONES,      32'hFFFF_FFFE, 32'hFFFF_FFFE);
        run_std("mulhsu_ones",   3'd2, ALL_ONES,     ALL_ONES,      32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_std("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'h0);
        run_std("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'h0);
        run_std("divu_100_7",    3'd5, 32'd100,      32'd7,         32'd14,        32'h0);
        run_std("remu_100_7",    3'd7, 32'd100,      32'd7,         32'd2,         32'h0);
        run_std("divu_by0",      3'd5, 32'd5,        32'd0,         ALL_ONES,      32'h0);
        run_std("rem_by0",       3'd6, 32'd5,        32'd0,         32'd5,         32'h0);
        run_std("div_ovf",       3'd4, MIN_INT,      ALL_ONES,      MIN_INT,       32'h0);
        run_std("rem_ovf",       3'd6, MIN_INT,      ALL_ONES,      32'h0,         32'h0);
        run_std("div_9_3",       3'd4, 32'd9,        32'd3,         32'd3,         32'h0);

        // A start during the run is ignored; the next op is issued in the done cycle.
        run_op("mul_inject", 3'd0, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 34, 10, 3'd0, 32'd2, 32'd2);
        run_std("mul_b2b",       3'd0, 32'd3,        32'd4,         32'd12,        32'd12);
        @(negedge clk);
        chk("idle_after_b2b_busy", busy, 1'b0);
        chk("idle_after_b2b_done", done, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  ro;
            logic [31:0] rx, ry;
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = (i == 5) ? 32'd0 : $urandom;
            if (i == 6) ry = ry & 32'hFF;
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry, model(ro, rx, ry),
                   ro[2] && !DIV_EN, model_lat(ro, rx, ry), 0, 3'd0, 32'd0, 32'd0);
        end

        // Reset part-way through an op must abort it without a done pulse.
        op = 3'd0; a = 32'd5; b = 32'd6; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_r", r, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("no_done_after_rst", seen, 0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
